// File: rtl/scaled_plane_pkg.sv
// -----------------------------------------------------------------------------
// scaled_plane_pkg
// Shared definitions for the scaled plane feeder:
//   - state_t        : feeder FSM states (IDLE, FETCH, BURST)
//   - DEF_*          : default parameter values of the feeder
//   - cnt_width()    : bit width needed to count 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package scaled_plane_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      BURST = 2'd2
   } state_t;

   localparam int DEF_DATA_W     = 24;
   localparam int DEF_SRC_W      = 80;
   localparam int DEF_SRC_H      = 60;
   localparam int DEF_SCALE_X    = 8;
   localparam int DEF_SCALE_Y    = 8;
   localparam int DEF_ADDR_W     = 13;
   localparam int DEF_USEDW_W    = 10;
   localparam int DEF_FILL_LIMIT = 500;

   // Smallest width w >= 1 such that 2**w >= n, i.e. enough to hold n-1.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/plane_addr_gen.sv
// -----------------------------------------------------------------------------
// plane_addr_gen
// Walks the source plane in the order needed for vertical replication:
// each source row is read SCALE_Y times before moving on to the next row.
// Holds the col / rep / row counters and the ROM address (row*SRC_W + col),
// which is maintained incrementally so no multiplier is needed.
//
// Ports:
//   clock        in   clock
//   reset        in   asynchronous, active-high reset
//   i_clear      in   synchronous return to frame origin (wins over advance)
//   i_advance    in   step to the next source pixel position
//   o_address    out  ROM address of the current position
//   o_frame_end  out  current position is the last one of the frame
// -----------------------------------------------------------------------------
module plane_addr_gen
   import scaled_plane_pkg::*;
#(
   parameter int SRC_W   = DEF_SRC_W,
   parameter int SRC_H   = DEF_SRC_H,
   parameter int SCALE_Y = DEF_SCALE_Y,
   parameter int ADDR_W  = DEF_ADDR_W
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_frame_end
);

   localparam int COL_W = cnt_width(SRC_W);
   localparam int REP_W = cnt_width(SCALE_Y);
   localparam int ROW_W = cnt_width(SRC_H);

   logic [COL_W-1:0]  r_col;
   logic [REP_W-1:0]  r_rep;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_address;

   logic w_col_last;
   logic w_rep_last;
   logic w_row_last;

   assign w_col_last  = (r_col == COL_W'(SRC_W - 1));
   assign w_rep_last  = (r_rep == REP_W'(SCALE_Y - 1));
   assign w_row_last  = (r_row == ROW_W'(SRC_H - 1));
   assign o_frame_end = w_col_last & w_rep_last & w_row_last;
   assign o_address   = r_address;

   // Position counters and address; clear has priority over advance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_col     <= '0;
         r_rep     <= '0;
         r_row     <= '0;
         r_address <= '0;
      end else if (i_clear) begin
         r_col     <= '0;
         r_rep     <= '0;
         r_row     <= '0;
         r_address <= '0;
      end else if (i_advance) begin
         if (!w_col_last) begin
            r_col     <= r_col + COL_W'(1);
            r_address <= r_address + ADDR_W'(1);
         end else begin
            r_col <= '0;
            if (!w_rep_last) begin
               // Replay the same source row: back to its first pixel.
               // Address is at row*SRC_W + SRC_W-1 here, so no underflow.
               r_rep     <= r_rep + REP_W'(1);
               r_address <= r_address - ADDR_W'(SRC_W - 1);
            end else if (!w_row_last) begin
               // Next row starts right after the last pixel of this one.
               r_rep     <= '0;
               r_row     <= r_row + ROW_W'(1);
               r_address <= r_address + ADDR_W'(1);
            end else begin
               r_rep     <= '0;
               r_row     <= '0;
               r_address <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/scaled_plane_feeder.sv
// -----------------------------------------------------------------------------
// scaled_plane_feeder
// Streams an SRC_W x SRC_H plane from a synchronous ROM into a FIFO, scaled
// up by pixel replication: every source pixel is written SCALE_X times in a
// row (one burst), and every source row is replayed SCALE_Y times.
// A burst is only started when the FIFO has room for a whole burst.
//
// Per burst: IDLE (decide) -> FETCH (ROM data settles) -> BURST (SCALE_X
// writes of the latched pixel). The ROM address only moves on BURST->IDLE,
// so the ROM output is valid by the end of the following FETCH cycle.
//
// Ports:
//   clock       in   clock
//   reset       in   asynchronous, active-high reset
//   enable      in   permit new bursts (a running burst always completes)
//   restart     in   synchronous pulse: back to frame origin, abort burst
//   rom_data    in   ROM read data, one cycle after address
//   wrusedw     in   FIFO fill level, sampled in IDLE only
//   address     out  ROM address (row*SRC_W + col)
//   fifo_data   out  pixel to the FIFO
//   wrreq       out  FIFO write strobe
//   frame_done  out  one-cycle pulse after the last write of a frame
// -----------------------------------------------------------------------------
module scaled_plane_feeder
   import scaled_plane_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int SRC_W      = DEF_SRC_W,
   parameter int SRC_H      = DEF_SRC_H,
   parameter int SCALE_X    = DEF_SCALE_X,
   parameter int SCALE_Y    = DEF_SCALE_Y,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int USEDW_W    = DEF_USEDW_W,
   parameter int FILL_LIMIT = DEF_FILL_LIMIT
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              restart,
   input  logic [DATA_W-1:0] rom_data,
   input  logic [USEDW_W-1:0] wrusedw,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] fifo_data,
   output logic              wrreq,
   output logic              frame_done
);

   // Parameter sanity: the plane must fit the ROM, scales must be positive,
   // and a burst admitted just below FILL_LIMIT must still fit the FIFO.
   if (SRC_W * SRC_H > (2 ** ADDR_W)) begin : g_bad_plane_size
      $error("scaled_plane_feeder: SRC_W*SRC_H exceeds ROM address space");
   end
   if ((SCALE_X < 1) || (SCALE_Y < 1)) begin : g_bad_scale
      $error("scaled_plane_feeder: SCALE_X and SCALE_Y must be >= 1");
   end
   if (FILL_LIMIT > ((2 ** USEDW_W) - SCALE_X)) begin : g_bad_fill_limit
      $error("scaled_plane_feeder: FILL_LIMIT leaves no room for a burst");
   end

   localparam int BEAT_W = cnt_width(SCALE_X);

   state_t              r_state;
   logic [BEAT_W-1:0]   r_beat;
   logic [DATA_W-1:0]   r_fifo_data;
   logic                r_wrreq;
   logic                r_frame_done;

   state_t              w_next_state;
   logic                w_latch;
   logic                w_advance;
   logic                w_next_wrreq;
   logic                w_next_frame_done;
   logic                w_beat_last;
   logic                w_room;
   logic                w_frame_end;
   logic [ADDR_W-1:0]   w_address;

   assign w_beat_last = (r_beat == BEAT_W'(SCALE_X - 1));
   assign w_room      = (wrusedw < USEDW_W'(FILL_LIMIT));

   plane_addr_gen #(
      .SRC_W   (SRC_W),
      .SRC_H   (SRC_H),
      .SCALE_Y (SCALE_Y),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (restart),
      .i_advance   (w_advance),
      .o_address   (w_address),
      .o_frame_end (w_frame_end)
   );

   // Next-state and registered-output decode; restart overrides everything.
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_advance    = 1'b0;
      if (restart) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable && w_room) begin
                  w_next_state = FETCH;
               end else begin
                  w_next_state = IDLE;
               end
            end
            FETCH: begin
               w_next_state = BURST;
               w_latch      = 1'b1;
            end
            BURST: begin
               if (w_beat_last) begin
                  w_next_state = IDLE;
                  w_advance    = 1'b1;
               end else begin
                  w_next_state = BURST;
               end
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end
      w_next_wrreq      = (w_next_state == BURST);
      w_next_frame_done = w_advance & w_frame_end;
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Output registers and burst beat counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_beat       <= '0;
         r_fifo_data  <= '0;
         r_wrreq      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_wrreq      <= w_next_wrreq;
         r_frame_done <= w_next_frame_done;
         if (w_latch) begin
            r_fifo_data <= rom_data;
         end
         // Beat 0 on entry from FETCH, count while the burst continues.
         if ((r_state == BURST) && (w_next_state == BURST)) begin
            r_beat <= r_beat + BEAT_W'(1);
         end else begin
            r_beat <= '0;
         end
      end
   end

   assign address    = w_address;
   assign fifo_data  = r_fifo_data;
   assign wrreq      = r_wrreq;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scaled_plane_feeder.sv
// -----------------------------------------------------------------------------
// tb_scaled_plane_feeder
// Two instances: u_dut with default parameters and u_small with a 4x2 plane
// scaled 2x3. Each has a synchronous ROM model whose contents encode the
// address, and a write monitor that pops expected {pixel, address} records
// from a scoreboard queue on every wrreq.
// -----------------------------------------------------------------------------
module tb_scaled_plane_feeder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        enable, restart;
   logic [23:0] rom_data;
   logic [9:0]  wrusedw;
   logic [12:0] address;
   logic [23:0] fifo_data;
   logic        wrreq, frame_done;

   logic        enable2, restart2;
   logic [23:0] rom_data2;
   logic [9:0]  wrusedw2;
   logic [12:0] address2;
   logic [23:0] fifo_data2;
   logic        wrreq2, frame_done2;

   scaled_plane_feeder u_dut (
      .clock(clock), .reset(reset), .enable(enable), .restart(restart),
      .rom_data(rom_data), .wrusedw(wrusedw), .address(address),
      .fifo_data(fifo_data), .wrreq(wrreq), .frame_done(frame_done)
   );

   scaled_plane_feeder #(.SRC_W(4), .SRC_H(2), .SCALE_X(2), .SCALE_Y(3)) u_small (
      .clock(clock), .reset(reset), .enable(enable2), .restart(restart2),
      .rom_data(rom_data2), .wrusedw(wrusedw2), .address(address2),
      .fifo_data(fifo_data2), .wrreq(wrreq2), .frame_done(frame_done2)
   );

   function automatic logic [23:0] rom_val(input logic [12:0] a);
      return {8'hC3, 3'b000, a};
   endfunction
   function automatic logic [23:0] rom_val2(input logic [12:0] a);
      return {8'h5A, 3'b000, a};
   endfunction

   // Synchronous ROM models, one cycle of read latency.
   always @(posedge clock) begin
      rom_data  <= rom_val(address);
      rom_data2 <= rom_val2(address2);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   typedef struct packed {
      logic [23:0] data;
      logic [12:0] addr;
   } exp_t;

   exp_t q[$];
   exp_t q2[$];
   exp_t mon_e, mon_e2;
   int   wcnt = 0, wcnt2 = 0, fd2_cnt = 0;

   // Write monitors: every write must match the next scoreboard record.
   always @(negedge clock) begin
      if (wrreq) begin
         wcnt++;
         if (q.size() == 0) begin
            check("unexpected_write", int'(fifo_data), -1);
         end else begin
            mon_e = q.pop_front();
            check("write_data", int'(fifo_data), int'(mon_e.data));
            check("write_addr", int'(address), int'(mon_e.addr));
         end
      end
      if (frame_done) begin
         check("unexpected_frame_done", 1, 0);
      end
      if (wrreq2) begin
         wcnt2++;
         if (q2.size() == 0) begin
            check("unexpected_write2", int'(fifo_data2), -1);
         end else begin
            mon_e2 = q2.pop_front();
            check("write_data2", int'(fifo_data2), int'(mon_e2.data));
            check("write_addr2", int'(address2), int'(mon_e2.addr));
         end
      end
      if (frame_done2) begin
         fd2_cnt++;
         check("frame_done2_align", wcnt2 % 48, 0);
      end
   end

   task automatic push_n(input int a, input int n);
      for (int k = 0; k < n; k++) q.push_back('{data: rom_val(13'(a)), addr: 13'(a)});
   endtask

   // Default plane: burst b is column b%80 of row b/640 (each row read 8x).
   task automatic push_bursts(input int nb);
      for (int b = 0; b < nb; b++) push_n(((b / 640) % 60) * 80 + (b % 80), 8);
   endtask

   // Small plane: 4 columns, 3 replays per row, 2 rows, 2 writes per burst.
   task automatic push_bursts2(input int nb);
      int a;
      for (int b = 0; b < nb; b++) begin
         a = ((b / 12) % 2) * 4 + (b % 4);
         for (int k = 0; k < 2; k++) q2.push_back('{data: rom_val2(13'(a)), addr: 13'(a)});
      end
   endtask

   task automatic restart_pulse();
      enable = 1'b0;
      @(negedge clock); restart = 1'b1;
      @(negedge clock); restart = 1'b0;
      q.delete();
   endtask

   // Wait until all expected writes are seen, then stop new bursts.
   task automatic drain(input int limit);
      int n;
      n = 0;
      do begin @(posedge clock); n++; end while ((q.size() != 0) && (n < limit));
      #1 enable = 1'b0;
      check("drain_complete", q.size(), 0);
   endtask

   task automatic drain2(input int limit);
      int n;
      n = 0;
      do begin @(posedge clock); n++; end while ((q2.size() != 0) && (n < limit));
      #1 enable2 = 1'b0;
      check("drain2_complete", q2.size(), 0);
   endtask

   typedef struct {
      logic       en;
      logic [9:0] used;
      int         exp_writes;
      int         exp_first;
   } vec_t;
   vec_t vecs[6];

   int base, n, writes, first;

   initial begin
      vecs[0] = '{en: 1'b1, used: 10'd500,  exp_writes: 0, exp_first: 0};
      vecs[1] = '{en: 1'b1, used: 10'd499,  exp_writes: 8, exp_first: 2};
      vecs[2] = '{en: 1'b0, used: 10'd0,    exp_writes: 0, exp_first: 0};
      vecs[3] = '{en: 1'b1, used: 10'd1000, exp_writes: 0, exp_first: 0};
      vecs[4] = '{en: 1'b1, used: 10'd0,    exp_writes: 8, exp_first: 2};
      vecs[5] = '{en: 1'b1, used: 10'd1023, exp_writes: 0, exp_first: 0};

      reset = 1'b1; enable = 1'b0; restart = 1'b0; wrusedw = 10'd0;
      enable2 = 1'b0; restart2 = 1'b0; wrusedw2 = 10'd0;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_wrreq", int'(wrreq), 0);
      check("rst_address", int'(address), 0);
      check("rst_fifo_data", int'(fifo_data), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_wrreq2", int'(wrreq2), 0);
      check("rst_address2", int'(address2), 0);

      // First burst after reset release: 8 writes of ROM[0], then address 1.
      enable = 1'b1;
      push_n(0, 8);
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (k == 1) begin
            check("first_fetch_wrreq", int'(wrreq), 0);
            enable = 1'b0;
         end else if (k <= 9) begin
            check("first_burst_wrreq", int'(wrreq), 1);
         end else begin
            check("first_post_wrreq", int'(wrreq), 0);
            check("first_post_address", int'(address), 1);
         end
      end
      check("first_sb_empty", q.size(), 0);

      // Fill-level / enable admission table: one IDLE decision per vector.
      for (int v = 0; v < 6; v++) begin
         restart_pulse();
         enable  = vecs[v].en;
         wrusedw = vecs[v].used;
         if (vecs[v].exp_writes > 0) push_n(0, 8);
         @(negedge clock);
         enable  = 1'b0;
         writes  = 0;
         first   = 0;
         for (int k = 1; k <= 50; k++) begin
            if (wrreq) begin
               writes++;
               if (first == 0) first = k;
            end
            @(negedge clock);
         end
         wrusedw = 10'd0;
         check($sformatf("vec%0d_writes", v), writes, vecs[v].exp_writes);
         check($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
         check($sformatf("vec%0d_sb_empty", v), q.size(), 0);
      end

      // Fill rises and enable drops mid-burst: all 8 writes still happen.
      restart_pulse();
      enable = 1'b1;
      push_n(0, 8);
      n = 0;
      do begin @(negedge clock); n++; end while (!wrreq && (n < 10));
      wrusedw = 10'd1000;
      enable  = 1'b0;
      writes  = 0;
      for (int k = 0; k < 20; k++) begin
         if (wrreq) writes++;
         @(negedge clock);
      end
      wrusedw = 10'd0;
      check("midburst_writes", writes, 8);
      check("midburst_sb_empty", q.size(), 0);

      // Long run: first 8 row replays of row 0, then row 1 starts at 80.
      restart_pulse();
      push_bursts(648);
      enable = 1'b1;
      drain(8000);

      // Restart on the 4th write of the burst at address 37.
      restart_pulse();
      push_bursts(37);
      push_n(37, 4);
      base = wcnt;
      enable = 1'b1;
      n = 0;
      do begin @(posedge clock); n++; end while (((wcnt - base) < 37 * 8 + 3) && (n < 2000));
      #1 restart = 1'b1;
      enable = 1'b0;
      @(posedge clock);
      #1 restart = 1'b0;
      @(negedge clock);
      check("restart_wrreq", int'(wrreq), 0);
      check("restart_address", int'(address), 0);
      check("restart_sb_empty", q.size(), 0);
      push_n(0, 8);
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      drain(40);

      // Reset on the 3rd write of a burst: wrreq drops without a clock edge.
      restart_pulse();
      push_n(0, 8);
      base = wcnt;
      enable = 1'b1;
      n = 0;
      do begin @(posedge clock); n++; end while (((wcnt - base) < 2) && (n < 40));
      #1 reset = 1'b1;
      #1;
      check("async_rst_wrreq", int'(wrreq), 0);
      check("async_rst_address", int'(address), 0);
      check("async_rst_fifo_data", int'(fifo_data), 0);
      enable = 1'b0;
      q.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      push_n(0, 8);
      enable = 1'b1;
      @(negedge clock);
      enable = 1'b0;
      drain(40);

      // Small plane: two full frames of 48 writes, one frame_done each.
      fd2_cnt = 0;
      push_bursts2(48);
      enable2 = 1'b1;
      drain2(500);
      repeat (3) @(negedge clock);
      check("small_frame_done_count", fd2_cnt, 2);
      check("small_address_origin", int'(address2), 0);
      check("small_frames_writes", wcnt2, 96);

      // Small plane: restart coincident with the last write of the frame.
      fd2_cnt = 0;
      push_bursts2(24);
      base = wcnt2;
      enable2 = 1'b1;
      n = 0;
      do begin @(posedge clock); n++; end while (((wcnt2 - base) < 47) && (n < 500));
      #1 restart2 = 1'b1;
      enable2 = 1'b0;
      @(posedge clock);
      #1 restart2 = 1'b0;
      repeat (3) @(negedge clock);
      check("restart_frame_end_fd", fd2_cnt, 0);
      check("restart_frame_end_addr", int'(address2), 0);
      check("restart_frame_end_wrreq", int'(wrreq2), 0);
      check("restart_frame_end_writes", wcnt2 - base, 48);
      check("restart_frame_end_sb", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/scaled_plane_feeder.md
SCALED_PLANE_FEEDER -- requirements
Module: scaled_plane_feeder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 24: pixel width.
- SRC_W, 80: source pixels per row.
- SRC_H, 60: source rows.
- SCALE_X, 8: horizontal replication.
- SCALE_Y, 8: vertical replication.
- ADDR_W, 13: ROM address width.
- USEDW_W, 10: FIFO fill-count width.
- FILL_LIMIT, 500: a burst starts only when wrusedw < FILL_LIMIT.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  permit new bursts.
- restart  in  1  synchronous pulse; return to frame origin.
- rom_data  in  DATA_W  synchronous-ROM read data, 1-cycle latency.
- wrusedw  in  USEDW_W  downstream FIFO fill level.
- address  out  ADDR_W  ROM address.
- fifo_data  out  DATA_W  pixel to FIFO.
- wrreq  out  1  FIFO write strobe.
- frame_done  out  1  one-cycle pulse after the last write of a frame.
REQ-003 Elaboration SHALL fail if SRC_W*SRC_H > 2**ADDR_W, if SCALE_X < 1 or SCALE_Y < 1, or if FILL_LIMIT > 2**USEDW_W - SCALE_X.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH and BURST.
REQ-005 IDLE SHALL go to FETCH when enable=1 and wrusedw < FILL_LIMIT, and SHALL stay in IDLE otherwise.
REQ-006 FETCH SHALL last exactly one cycle; on FETCH->BURST the block SHALL latch rom_data into the pixel register.
REQ-007 BURST SHALL last exactly SCALE_X cycles, with wrreq=1 and fifo_data=pixel register on every cycle; it SHALL then return to IDLE.
REQ-008 wrreq SHALL be 0 in IDLE and FETCH; first wrreq SHALL occur 2 cycles after the IDLE cycle that satisfied REQ-005.
REQ-009 address SHALL change only on the BURST->IDLE edge, so it is stable for at least one cycle before each FETCH.
REQ-010 Counters SHALL be col (0..SRC_W-1), rep (0..SCALE_Y-1) and row (0..SRC_H-1); address SHALL equal row*SRC_W+col.
REQ-011 At burst end the counters SHALL update as follows:
- col<SRC_W-1: col+1.
- Otherwise col=0, and then:
  - rep<SCALE_Y-1: rep+1, address rewinds to row start.
  - rep=SCALE_Y-1, row<SRC_H-1: rep=0, row+1.
  - rep=SCALE_Y-1, row=SRC_H-1 (frame end): all counters 0, address 0, frame_done=1 for the next cycle.
REQ-012 A frame SHALL contain exactly SRC_W*SCALE_X*SRC_H*SCALE_Y writes.
REQ-013 Deasserting enable mid-burst SHALL NOT truncate the burst; only new bursts are blocked.
REQ-014 wrusedw SHALL be sampled only in IDLE; rising fill during a burst SHALL NOT stop it.
REQ-015 restart=1 SHALL, on the next edge, force IDLE, zero the counters and address, and drop wrreq; this SHALL take priority over all other transitions, including burst completion and frame end (frame_done stays 0).
REQ-016 All address arithmetic SHALL be unsigned ADDR_W-bit and SHALL never wrap past 2**ADDR_W.

Reset
REQ-017 During reset the block SHALL hold state=IDLE, address=0, fifo_data=0, wrreq=0, frame_done=0 and all counters at 0.
REQ-018 Reset asserted mid-burst SHALL drop wrreq immediately (asynchronously); after release the block SHALL resume at frame origin.

Structure
REQ-019 Package scaled_plane_pkg SHALL hold the state_t enum (IDLE, FETCH, BURST) and the default parameter constants.
REQ-020 Sub-module plane_addr_gen SHALL own col/rep/row and address, advancing on an "advance" strobe and clearing on "clear"; the FSM and output registers SHALL stay in the top module.

Verification
REQ-021 Defaults, wrusedw=0, enable=1 after reset: wrreq high for 8 cycles starting 2 cycles after release, fifo_data=ROM[0], then address=1.
REQ-022 Defaults: address sequence 0..79 repeats 8 times, then 80..159; the 640th write uses ROM[79] and the 641st uses ROM[0].
REQ-023 SRC_W=4, SRC_H=2, SCALE_X=2, SCALE_Y=3: exactly 48 writes per frame; frame_done pulses once; address returns to 0 and the second frame is identical.
REQ-024 wrusedw=500: no wrreq for 50 cycles; wrusedw=499: burst begins within 2 cycles; wrusedw raised to 1000 mid-burst: all 8 writes still complete.
REQ-025 restart on the 4th write of the burst at address 37: wrreq=0 next cycle, address=0, next burst outputs ROM[0]; restart coincident with frame end: frame_done stays 0.
REQ-026 Reset asserted on the 3rd write of a burst: wrreq=0 immediately; after release the first write outputs ROM[0].
